// File: rtl/boq_axil_master.sv
// Single-outstanding AXI4-Lite master: turns one cmd_* request into an AW/W/B or AR/R exchange
// and returns the result on rsp_*. Define BOQ_AXIL_MASTER_TIMEOUT_EN to enable the watchdog.
module boq_axil_master #(
    parameter int          C_M_AXI_ADDR_WIDTH = 32,
    parameter logic [31:0] C_BASE_ADDRESS     = 32'h0000_0000,
    parameter int          C_TIMEOUT_CYCLES   = 1024
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_rnw,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]                   cmd_wdata,

    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [31:0]                   rsp_rdata,
    output logic [1:0]                    rsp_resp,

    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [31:0]                   M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [31:0]                   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WADDR = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_RADDR = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] L_BASE = C_M_AXI_ADDR_WIDTH'(C_BASE_ADDRESS);

    logic [2:0]                    r_state;
    logic                          r_cmd_ready;
    logic                          r_awvalid;
    logic                          r_wvalid;
    logic                          r_bready;
    logic                          r_arvalid;
    logic                          r_rready;
    logic                          r_rsp_valid;
    logic [31:0]                   r_rsp_rdata;
    logic [1:0]                    r_rsp_resp;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
    logic [31:0]                   r_wdata;

    logic w_phase_done;
    logic w_timeout;

    // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        w_phase_done = 1'b0;
        case (r_state)
            S_WADDR: w_phase_done = (!r_awvalid || M_AXI_AWREADY) && (!r_wvalid || M_AXI_WREADY);
            S_WRESP: w_phase_done = M_AXI_BVALID;
            S_RADDR: w_phase_done = M_AXI_ARREADY;
            S_RDATA: w_phase_done = M_AXI_RVALID;
            default: w_phase_done = 1'b0;
        endcase
    end

`ifdef BOQ_AXIL_MASTER_TIMEOUT_EN
    localparam int L_TCNT_W = $clog2(C_TIMEOUT_CYCLES + 1);

    logic [L_TCNT_W-1:0] r_tcount;
    logic                w_waiting;

    assign w_waiting = (r_state == S_WADDR) || (r_state == S_WRESP) ||
                       (r_state == S_RADDR) || (r_state == S_RDATA);
    assign w_timeout = w_waiting && (r_tcount == L_TCNT_W'(C_TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcount <= '0;
        end else if (r_state == S_IDLE) begin
            r_tcount <= '0;
        end else if (w_waiting) begin
            r_tcount <= r_tcount + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments only; a later assignment in the same
    // block deliberately overrides an earlier one (the watchdog branch below relies on this).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_resp  <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_cmd_ready && cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        if (cmd_rnw) begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_RADDR;
                        end else begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WADDR;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_WADDR: begin
                    // AW and W retire independently; each VALID falls after its own handshake.
                    if (M_AXI_AWREADY) r_awvalid <= 1'b0;
                    if (M_AXI_WREADY)  r_wvalid  <= 1'b0;
                    if (w_phase_done) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (M_AXI_BVALID) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= M_AXI_BRESP;
                        r_rsp_rdata <= 32'h0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RADDR: begin
                    if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (M_AXI_RVALID) begin
                        r_rready    <= 1'b0;
                        r_rsp_resp  <= M_AXI_RRESP;
                        r_rsp_rdata <= M_AXI_RDATA;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // A handshake completing on the expiry cycle wins, so the slave never sees a lost beat.
            if (w_timeout && !w_phase_done) begin
                r_awvalid   <= 1'b0;
                r_wvalid    <= 1'b0;
                r_bready    <= 1'b0;
                r_arvalid   <= 1'b0;
                r_rready    <= 1'b0;
                r_rsp_resp  <= 2'b10;
                r_rsp_rdata <= 32'hDEAD_BEEF;
                r_rsp_valid <= 1'b1;
                r_state     <= S_RESP;
            end
        end
    end

    // NOTE: the address/data holding registers carry no reset; they are only observed while a
    // VALID that is itself reset is high, so leaving them out keeps the reset tree small.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && r_cmd_ready && cmd_valid) begin
            r_addr  <= cmd_addr | L_BASE;
            r_wdata <= cmd_wdata;
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_boq_axil_master.sv
// Directed bench for boq_axil_master: the AXI slave side is driven cycle by cycle from each task.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
module tb_boq_axil_master;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rnw;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int n_checks = 0;
    int n_fail   = 0;
    int b_hs     = 0;

    boq_axil_master #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_BASE_ADDRESS    (BASE),
        .C_TIMEOUT_CYCLES  (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rnw      (cmd_rnw),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .M_AXI_AWADDR (awaddr),
        .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA  (wdata),
        .M_AXI_WSTRB  (wstrb),
        .M_AXI_WVALID (wvalid),
        .M_AXI_WREADY (wready),
        .M_AXI_BRESP  (bresp),
        .M_AXI_BVALID (bvalid),
        .M_AXI_BREADY (bready),
        .M_AXI_ARADDR (araddr),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA  (rdata),
        .M_AXI_RRESP  (rresp),
        .M_AXI_RVALID (rvalid),
        .M_AXI_RREADY (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && bvalid && bready) b_hs <= b_hs + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_slave();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0;
    endtask

    // Write with a slave that is ready at once: accept c0, VALIDs c1, BVALID c2, rsp_valid c3.
    task automatic run_write(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] br);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_cmd_ready_idle: got %b want 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = addr; cmd_wdata = data;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
        step();
        cmd_valid = 1'b0;
        n_checks++; if ({awvalid, wvalid, cmd_ready} !== 3'b110) begin n_fail++; $display("FAIL wr_c1_valids: got aw/w/cmd_ready=%b want 110", {awvalid, wvalid, cmd_ready}); end
        n_checks++; if (awaddr !== (BASE | addr)) begin n_fail++; $display("FAIL wr_awaddr: got %h want %h", awaddr, BASE | addr); end
        n_checks++; if ({wdata, wstrb} !== {data, 4'hF}) begin n_fail++; $display("FAIL wr_wdata_wstrb: got %h/%h want %h/f", wdata, wstrb, data); end
        bvalid = 1'b1; bresp = br;
        step();
        n_checks++; if ({bready, awvalid, wvalid, rsp_valid} !== 4'b1000) begin n_fail++; $display("FAIL wr_c2_bready: got b/aw/w/rsp=%b want 1000", {bready, awvalid, wvalid, rsp_valid}); end
        step();
        bvalid = 1'b0; bresp = 2'b00;
        n_checks++; if ({rsp_valid, bready} !== 2'b10) begin n_fail++; $display("FAIL wr_c3_rsp_valid: got rsp/bready=%b want 10", {rsp_valid, bready}); end
        n_checks++; if ({rsp_resp, rsp_rdata} !== {br, 32'h0}) begin n_fail++; $display("FAIL wr_c3_payload: got %b/%h want %b/00000000", rsp_resp, rsp_rdata, br); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        idle_slave();
        n_checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL wr_back_idle: got rsp/cmd_ready=%b want 01", {rsp_valid, cmd_ready}); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; rsp_ready = 1'b0;
        idle_slave();
        repeat (3) step();
        n_checks++; if ({cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 7'b0) begin n_fail++; $display("FAIL rst_handshakes: got %b want 0000000", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}); end
        n_checks++; if ({rsp_rdata, rsp_resp} !== 34'h0) begin n_fail++; $display("FAIL rst_payload: got %h/%b want 0/00", rsp_rdata, rsp_resp); end
        reset = 1'b0;
        step();
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_write_basic();
        run_write(32'h10, 32'hA5A5_A5A5, 2'b00);
    endtask

    task automatic test_read_delay();
        cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 32'h4; arready = 1'b1;
        step();
        cmd_valid = 1'b0;
        n_checks++; if ({arvalid, awvalid, araddr} !== {2'b10, BASE | 32'h4}) begin n_fail++; $display("FAIL rd_c1_ar: got arvalid=%b awvalid=%b araddr=%h want 1/0/%h", arvalid, awvalid, araddr, BASE | 32'h4); end
        step();
        arready = 1'b0;
        n_checks++; if ({arvalid, rready} !== 2'b01) begin n_fail++; $display("FAIL rd_c2_rready: got ar/r=%b want 01", {arvalid, rready}); end
        for (int c = 3; c <= 9; c++) begin
            step();
            n_checks++; if ({rready, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL rd_wait_c%0d: got rready/rsp=%b want 10", c, {rready, rsp_valid}); end
        end
        rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
        step();
        rvalid = 1'b0; rdata = 32'hFFFF_FFFF; rresp = 2'b11;
        n_checks++; if ({rsp_valid, rready} !== 2'b10) begin n_fail++; $display("FAIL rd_rsp_valid: got rsp/rready=%b want 10", {rsp_valid, rready}); end
        n_checks++; if ({rsp_rdata, rsp_resp} !== {32'h1234_5678, 2'b00}) begin n_fail++; $display("FAIL rd_payload: got %h/%b want 12345678/00", rsp_rdata, rsp_resp); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        idle_slave();
        n_checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL rd_back_idle: got rsp/cmd_ready=%b want 01", {rsp_valid, cmd_ready}); end
    endtask

    task automatic test_write_wready_late();
        int b0;
        b0 = b_hs;
        cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 32'h20; cmd_wdata = 32'h0BAD_F00D;
        awready = 1'b1; wready = 1'b0;
        step();
        cmd_valid = 1'b0;
        n_checks++; if ({awvalid, wvalid} !== 2'b11) begin n_fail++; $display("FAIL wl_c1_valids: got aw/w=%b want 11", {awvalid, wvalid}); end
        step();
        awready = 1'b0;
        n_checks++; if ({awvalid, wvalid, bready} !== 3'b010) begin n_fail++; $display("FAIL wl_aw_first: got aw/w/b=%b want 010", {awvalid, wvalid, bready}); end
        for (int c = 3; c <= 6; c++) begin
            step();
            n_checks++; if ({wvalid, bready, wdata} !== {2'b10, 32'h0BAD_F00D}) begin n_fail++; $display("FAIL wl_w_hold_c%0d: got w/b=%b wdata=%h want 10/0badf00d", c, {wvalid, bready}, wdata); end
        end
        wready = 1'b1;
        step();
        wready = 1'b0;
        n_checks++; if ({wvalid, bready} !== 2'b01) begin n_fail++; $display("FAIL wl_w_done: got w/b=%b want 01", {wvalid, bready}); end
        bvalid = 1'b1; bresp = 2'b10;
        step();
        n_checks++; if ({rsp_valid, rsp_resp, rsp_rdata} !== {1'b1, 2'b10, 32'h0}) begin n_fail++; $display("FAIL wl_rsp: got v=%b resp=%b rdata=%h want 1/10/00000000", rsp_valid, rsp_resp, rsp_rdata); end
        step();
        bvalid = 1'b0; bresp = 2'b00;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        idle_slave();
        n_checks++; if ((b_hs - b0) !== 1) begin n_fail++; $display("FAIL wl_b_count: got %0d want 1", b_hs - b0); end
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 32'h30; cmd_wdata = 32'h1111_2222;
        awready = 1'b1; wready = 1'b1;
        step();
        cmd_valid = 1'b0;
        bvalid = 1'b1; bresp = 2'b11;
        step();
        step();
        bvalid = 1'b0; bresp = 2'b00;
        cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 32'h8;
        n_checks++; if ({rsp_valid, rsp_resp, rsp_rdata, cmd_ready} !== {1'b1, 2'b11, 32'h0, 1'b0}) begin n_fail++; $display("FAIL b2b_c3: got v=%b resp=%b rdata=%h cmd_ready=%b want 1/11/0/0", rsp_valid, rsp_resp, rsp_rdata, cmd_ready); end
        for (int c = 4; c <= 6; c++) begin
            step();
            n_checks++; if ({rsp_valid, rsp_resp, rsp_rdata, cmd_ready, arvalid} !== {1'b1, 2'b11, 32'h0, 2'b00}) begin n_fail++; $display("FAIL b2b_hold_c%0d: got v=%b resp=%b rdata=%h cmd_ready=%b arvalid=%b", c, rsp_valid, rsp_resp, rsp_rdata, cmd_ready, arvalid); end
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        arready = 1'b1;
        n_checks++; if ({rsp_valid, cmd_ready, arvalid} !== 3'b010) begin n_fail++; $display("FAIL b2b_after_rsp: got rsp/cmd_ready/ar=%b want 010", {rsp_valid, cmd_ready, arvalid}); end
        step();
        cmd_valid = 1'b0;
        n_checks++; if ({arvalid, cmd_ready, araddr} !== {2'b10, BASE | 32'h8}) begin n_fail++; $display("FAIL b2b_read_accept: got ar=%b cmd_ready=%b araddr=%h", arvalid, cmd_ready, araddr); end
        step();
        rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = 2'b01;
        step();
        rvalid = 1'b0;
        n_checks++; if ({rsp_valid, rsp_rdata, rsp_resp} !== {1'b1, 32'hCAFE_F00D, 2'b01}) begin n_fail++; $display("FAIL b2b_read_rsp: got v=%b rdata=%h resp=%b want 1/cafef00d/01", rsp_valid, rsp_rdata, rsp_resp); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        idle_slave();
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 32'h40; cmd_wdata = 32'h5555_5555;
        awready = 1'b1; wready = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        n_checks++; if (bready !== 1'b1) begin n_fail++; $display("FAIL rm_in_wresp: got bready=%b want 1", bready); end
        reset = 1'b1;
        step();
        n_checks++; if ({cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 7'b0) begin n_fail++; $display("FAIL rm_handshakes: got %b want 0000000", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}); end
        n_checks++; if ({rsp_rdata, rsp_resp} !== 34'h0) begin n_fail++; $display("FAIL rm_payload: got %h/%b want 0/00", rsp_rdata, rsp_resp); end
        reset = 1'b0;
        idle_slave();
        for (int c = 0; c < 4; c++) begin
            step();
            if (rsp_valid) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rm_no_rsp: got %0d rsp_valid cycles want 0", seen); end
        run_write(32'h44, 32'h7777_7777, 2'b00);
    endtask

`ifdef BOQ_AXIL_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 32'hC; arready = 1'b0;
        step();
        cmd_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 60) begin
            step();
            n++;
        end
        n_checks++; if (rsp_valid !== 1'b1 || n < 16 || n > 17) begin n_fail++; $display("FAIL to_latency: rsp_valid=%b at cycle %0d want 1 at 16..17", rsp_valid, n); end
        n_checks++; if ({rsp_resp, rsp_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL to_payload: got %b/%h want 10/deadbeef", rsp_resp, rsp_rdata); end
        n_checks++; if ({arvalid, rready} !== 2'b00) begin n_fail++; $display("FAIL to_dropped: got ar/r=%b want 00", {arvalid, rready}); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_checks++; if ({arvalid, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL to_back_idle: got ar/cmd_ready=%b want 01", {arvalid, cmd_ready}); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_basic();
        test_read_delay();
        test_write_wready_late();
        test_back_to_back();
        test_reset_mid();
`ifdef BOQ_AXIL_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
